wasca_mul_sequencer: RTL and testbench

Sequences and shares the three-partial-product 16x16 multiplier cell (p1 = a_lo·b_lo, p2 = a_lo·b_hi, p3 = a_hi·b_lo) between two requesters. It registers operands, drives the cell's enable, and waits out the cell's registered-product latency. It then combines the partials into the low 32 bits of a 32x32 product and returns the result over a valid/ready response channel. It sits between the cell and its clients (CPU-side custom-instruction port 0, DMA/bus-side port 1) in the wasca FPGA design.

---
 rtl/wasca_mul_sequencer_if.sv | 48 ++++
 rtl/wasca_mul_sequencer.sv | 147 ++++++++++++++
 tb/tb_wasca_mul_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wasca_mul_sequencer_if.sv
// wasca_mul_sequencer_if
// Groups every signal between the multiplier sequencer and its surroundings:
// the two requester channels, the two response channels with the shared
// result bus, the busy flag, and the connection to the partial-product cell.
//   slave  : the sequencer itself
//   master : the surroundings (requesters, response consumers, multiplier cell)
interface wasca_mul_sequencer_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;

    logic        rsp0_valid;
    logic        rsp0_ready;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [31:0] rsp_result;
    logic        busy;

    logic [31:0] mul_src1;
    logic [31:0] mul_src2;
    logic        mul_en;
    logic [31:0] mul_p1;
    logic [31:0] mul_p2;
    logic [31:0] mul_p3;

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready,
        input  mul_p1, mul_p2, mul_p3,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_result, busy,
        output mul_src1, mul_src2, mul_en
    );

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        output rsp0_ready, rsp1_ready,
        output mul_p1, mul_p2, mul_p3,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_result, busy,
        input  mul_src1, mul_src2, mul_en
    );
endinterface

// File: rtl/wasca_mul_sequencer.sv
// wasca_mul_sequencer
// Shares one three-partial-product 16x16 multiplier cell between two
// requesters (port 0: CPU custom instruction, port 1: DMA/bus side) and
// returns the low 32 bits of the 32x32 product on a valid/ready channel.
//
// Ports:
//   clk    sole clock, rising edge
//   reset  synchronous, active-high
//   bus    wasca_mul_sequencer_if.slave: requests, responses, busy, cell link
//
// Parameter:
//   MUL_LATENCY  cycles from a cell edge with mul_en=1 to stable products (1..7)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | arbitrate, accept one request, latch operands
// S_ISSUE   | mul_en=1 for exactly one cycle
// S_WAIT    | cell holds its products, count out remaining latency
// S_COMBINE | sum partials into result_q
// S_RESP    | present result to owner until it is consumed
module wasca_mul_sequencer #(
    parameter int MUL_LATENCY = 1
) (
    input  logic clk,
    input  logic reset,
    wasca_mul_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_COMBINE,
        S_RESP
    } state_t;

    localparam logic [2:0] WAIT_LOAD = 3'(MUL_LATENCY - 1);

    state_t      state;
    logic [2:0]  wait_cnt;
    logic        last_grant;
    logic        owner;
    logic [31:0] src1_q;
    logic [31:0] src2_q;
    logic [31:0] result_q;
    logic        mul_en_q;
    logic        busy_q;
    logic        rsp0_valid_q;
    logic        rsp1_valid_q;

    logic        grant0;
    logic        grant1;
    logic        ready0;
    logic        ready1;
    logic        accept;
    logic        rsp_done;

    // On a tie the port that did not win last time is served.
    assign grant0 = bus.req0_valid & (~bus.req1_valid | last_grant);
    assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);

    // Ready is held low in the reset cycle so nothing looks accepted while
    // the state is being forced back to idle.
    assign ready0 = (state == S_IDLE) & ~reset & grant0;
    assign ready1 = (state == S_IDLE) & ~reset & grant1;
    assign accept = ready0 | ready1;

    assign rsp_done = owner ? (rsp1_valid_q & bus.rsp1_ready)
                            : (rsp0_valid_q & bus.rsp0_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            wait_cnt     <= 3'd0;
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            src1_q       <= 32'd0;
            src2_q       <= 32'd0;
            result_q     <= 32'd0;
            mul_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        owner      <= grant1;
                        last_grant <= grant1;
                        src1_q     <= grant1 ? bus.req1_a : bus.req0_a;
                        src2_q     <= grant1 ? bus.req1_b : bus.req0_b;
                        mul_en_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mul_en_q <= 1'b0;
                    if (MUL_LATENCY == 1) begin
                        state <= S_COMBINE;
                    end else begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 3'd1) begin
                        state <= S_COMBINE;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                S_COMBINE: begin
                    // Summing the full cross terms before the shift is
                    // equivalent to summing their low halves: everything
                    // above bit 15 of the sum is shifted out of the result.
                    result_q     <= bus.mul_p1 + ((bus.mul_p2 + bus.mul_p3) << 16);
                    rsp0_valid_q <= ~owner;
                    rsp1_valid_q <= owner;
                    state        <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_done) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp_result = result_q;
    assign bus.busy       = busy_q;
    assign bus.mul_src1   = src1_q;
    assign bus.mul_src2   = src2_q;
    assign bus.mul_en     = mul_en_q;

endmodule

// File: tb/tb_wasca_mul_sequencer.sv
// tb_wasca_mul_sequencer
// Directed bench for wasca_mul_sequencer. dut1 uses the default cell latency
// of 1, dut3 uses a latency of 3. Each has a behavioural partial-product cell
// model; the slow model shows garbage until its products are due.
module tb_wasca_mul_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wasca_mul_sequencer_if bus1();
    wasca_mul_sequencer_if bus3();

    wasca_mul_sequencer #(.MUL_LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    wasca_mul_sequencer #(.MUL_LATENCY(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

    // latency-1 cell
    always @(posedge clk) begin
        if (reset) begin
            bus1.mul_p1 <= 32'd0;
            bus1.mul_p2 <= 32'd0;
            bus1.mul_p3 <= 32'd0;
        end else if (bus1.mul_en) begin
            bus1.mul_p1 <= 32'(bus1.mul_src1[15:0]) * 32'(bus1.mul_src2[15:0]);
            bus1.mul_p2 <= 32'(bus1.mul_src1[15:0]) * 32'(bus1.mul_src2[31:16]);
            bus1.mul_p3 <= 32'(bus1.mul_src1[31:16]) * 32'(bus1.mul_src2[15:0]);
        end
    end

    // latency-3 cell
    logic [31:0] c3_pend1, c3_pend2, c3_pend3;
    int          c3_dly;
    always @(posedge clk) begin
        if (reset) begin
            bus3.mul_p1 <= 32'd0;
            bus3.mul_p2 <= 32'd0;
            bus3.mul_p3 <= 32'd0;
            c3_dly      <= 0;
        end else if (bus3.mul_en) begin
            c3_pend1    <= 32'(bus3.mul_src1[15:0]) * 32'(bus3.mul_src2[15:0]);
            c3_pend2    <= 32'(bus3.mul_src1[15:0]) * 32'(bus3.mul_src2[31:16]);
            c3_pend3    <= 32'(bus3.mul_src1[31:16]) * 32'(bus3.mul_src2[15:0]);
            bus3.mul_p1 <= 32'hDEADBEEF;
            bus3.mul_p2 <= 32'hDEADBEEF;
            bus3.mul_p3 <= 32'hDEADBEEF;
            c3_dly      <= 2;
        end else if (c3_dly > 0) begin
            c3_dly <= c3_dly - 1;
            if (c3_dly == 1) begin
                bus3.mul_p1 <= c3_pend1;
                bus3.mul_p2 <= c3_pend2;
                bus3.mul_p3 <= c3_pend3;
            end
        end
    end

    int npass = 0;
    int ntot  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        assert (got === exp) begin
            npass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete operation on dut1, started in IDLE with the response port ready.
    task automatic run_op(input logic port, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        int n;
        if (port == 1'b0) begin
            bus1.req0_a = a; bus1.req0_b = b; bus1.req0_valid = 1'b1;
        end else begin
            bus1.req1_a = a; bus1.req1_b = b; bus1.req1_valid = 1'b1;
        end
        #1;
        chk({tag, "_ready"}, port ? bus1.req1_ready : bus1.req0_ready, 32'd1);
        chk({tag, "_other_ready"}, port ? bus1.req0_ready : bus1.req1_ready, 32'd0);
        step();
        chk({tag, "_mul_en"}, bus1.mul_en, 32'd1);
        chk({tag, "_busy"}, bus1.busy, 32'd1);
        bus1.req0_valid = 1'b0;
        bus1.req1_valid = 1'b0;
        bus1.req0_a = ~a; bus1.req0_b = ~b;
        bus1.req1_a = ~a; bus1.req1_b = ~b;
        n = 0;
        while (!(port ? bus1.rsp1_valid : bus1.rsp0_valid) && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, n, 32'd2);
        chk({tag, "_result"}, bus1.rsp_result, exp);
        chk({tag, "_other_rsp"}, port ? bus1.rsp0_valid : bus1.rsp1_valid, 32'd0);
        chk({tag, "_src1_held"}, bus1.mul_src1, a);
        step();
        chk({tag, "_rsp_drop"}, port ? bus1.rsp1_valid : bus1.rsp0_valid, 32'd0);
    endtask

    int          gexp[4] = '{0, 1, 0, 1};
    logic [31:0] va0[2]  = '{32'h3, 32'h00012345};
    logic [31:0] vb0[2]  = '{32'h5, 32'h00000100};
    logic [31:0] e0[2]   = '{32'h0000000F, 32'h01234500};
    logic [31:0] va1[2]  = '{32'h00010000, 32'h7};
    logic [31:0] vb1[2]  = '{32'h3, 32'hFFFFFFFF};
    logic [31:0] e1[2]   = '{32'h00030000, 32'hFFFFFFF9};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n, i0, i1, ng, nrsp, last_cyc;
        logic        acc0, acc1, pport, seen;
        logic [31:0] pexp, held;

        reset = 1'b1;
        bus1.req0_valid = 0; bus1.req1_valid = 0;
        bus1.req0_a = 0; bus1.req0_b = 0; bus1.req1_a = 0; bus1.req1_b = 0;
        bus1.rsp0_ready = 1; bus1.rsp1_ready = 1;
        bus3.req0_valid = 0; bus3.req1_valid = 0;
        bus3.req0_a = 0; bus3.req0_b = 0; bus3.req1_a = 0; bus3.req1_b = 0;
        bus3.rsp0_ready = 1; bus3.rsp1_ready = 1;
        bus1.req0_valid = 1'b1;
        step();
        step();
        chk("rst_req0_ready", bus1.req0_ready, 32'd0);
        chk("rst_busy", bus1.busy, 32'd0);
        chk("rst_rsp0_valid", bus1.rsp0_valid, 32'd0);
        chk("rst_mul_en", bus1.mul_en, 32'd0);
        chk("rst_src1", bus1.mul_src1, 32'd0);
        chk("rst_result", bus1.rsp_result, 32'd0);
        bus1.req0_valid = 1'b0;
        reset = 1'b0;
        step();

        run_op(1'b0, 32'h12345678, 32'h9ABCDEF0, 32'h242D2080, "p0_basic");
        run_op(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, "p1_ones");
        run_op(1'b1, 32'h00010000, 32'h00010000, 32'h00000000, "p1_wrap");

        // both ports request continuously; grants alternate starting with port 0
        bus1.req0_a = va0[0]; bus1.req0_b = vb0[0]; bus1.req0_valid = 1'b1;
        bus1.req1_a = va1[0]; bus1.req1_b = vb1[0]; bus1.req1_valid = 1'b1;
        i0 = 0; i1 = 0; ng = 0; nrsp = 0; last_cyc = 0; pport = 0; pexp = 0;
        #1;
        for (int cyc = 0; cyc < 60 && nrsp < 4; cyc++) begin
            acc0 = bus1.req0_ready;
            acc1 = bus1.req1_ready;
            if (acc0 || acc1) begin
                if (ng < 4) chk("alt_grant", acc1, gexp[ng]);
                if (ng > 0) chk("alt_interval", cyc - last_cyc, 32'd4);
                last_cyc = cyc;
                pport = acc1;
                pexp = acc1 ? e1[i1] : e0[i0];
                ng++;
            end
            if (bus1.rsp0_valid || bus1.rsp1_valid) begin
                chk("alt_rsp_port", bus1.rsp1_valid, pport);
                chk("alt_rsp_single", bus1.rsp0_valid & bus1.rsp1_valid, 32'd0);
                chk("alt_result", bus1.rsp_result, pexp);
                nrsp++;
            end
            step();
            if (acc0) begin
                i0++;
                if (i0 < 2) begin bus1.req0_a = va0[i0]; bus1.req0_b = vb0[i0]; end
                else bus1.req0_valid = 1'b0;
            end
            if (acc1) begin
                i1++;
                if (i1 < 2) begin bus1.req1_a = va1[i1]; bus1.req1_b = vb1[i1]; end
                else bus1.req1_valid = 1'b0;
            end
        end
        chk("alt_rsp_count", nrsp, 32'd4);
        bus1.req0_valid = 1'b0;
        bus1.req1_valid = 1'b0;
        step();

        // response backpressure on port 0 while port 1 waits
        bus1.rsp0_ready = 1'b0;
        bus1.req0_a = 32'h12345678; bus1.req0_b = 32'h9ABCDEF0; bus1.req0_valid = 1'b1;
        step();
        bus1.req0_valid = 1'b0;
        bus1.req1_a = 32'h3; bus1.req1_b = 32'h5; bus1.req1_valid = 1'b1;
        n = 0;
        while (!bus1.rsp0_valid && n < 20) begin step(); n++; end
        chk("bp_reach_resp", bus1.rsp0_valid, 32'd1);
        held = bus1.rsp_result;
        chk("bp_result", held, 32'h242D2080);
        for (int k = 0; k < 10; k++) begin
            chk("bp_hold_valid", bus1.rsp0_valid, 32'd1);
            chk("bp_hold_result", bus1.rsp_result, held);
            chk("bp_hold_ready", {bus1.req0_ready, bus1.req1_ready}, 32'd0);
            step();
        end
        bus1.rsp0_ready = 1'b1;
        #1;
        chk("bp_done_cycle_ready", bus1.req1_ready, 32'd0);
        step();
        chk("bp_after_valid", bus1.rsp0_valid, 32'd0);
        chk("bp_next_accept", bus1.req1_ready, 32'd1);
        step();
        bus1.req1_valid = 1'b0;
        n = 0;
        while (!bus1.rsp1_valid && n < 20) begin step(); n++; end
        chk("bp_p1_result", bus1.rsp_result, 32'h0000000F);
        step();

        // latency 3 on dut3
        bus3.req0_a = 32'h00020003; bus3.req0_b = 32'h00040005; bus3.req0_valid = 1'b1;
        #1;
        chk("l3_ready", bus3.req0_ready, 32'd1);
        step();
        bus3.req0_valid = 1'b0;
        chk("l3_en_t1", bus3.mul_en, 32'd1);
        step();
        chk("l3_en_t2", bus3.mul_en, 32'd0);
        chk("l3_busy_t2", bus3.busy, 32'd1);
        step();
        chk("l3_en_t3", bus3.mul_en, 32'd0);
        step();
        chk("l3_novalid_t4", bus3.rsp0_valid, 32'd0);
        step();
        chk("l3_valid_t5", bus3.rsp0_valid, 32'd1);
        chk("l3_result", bus3.rsp_result, 32'h0016000F);
        chk("l3_other_rsp", bus3.rsp1_valid, 32'd0);
        step();
        chk("l3_idle", bus3.busy, 32'd0);

        // reset while dut3 is in WAIT; dut1 is idle and requesting during the reset cycle
        bus3.req0_a = 32'hFFFFFFFF; bus3.req0_b = 32'hFFFFFFFF; bus3.req0_valid = 1'b1;
        step();
        bus3.req0_valid = 1'b0;
        step();
        reset = 1'b1;
        bus1.req0_valid = 1'b1;
        #1;
        chk("rw_rst_cycle_ready", bus1.req0_ready, 32'd0);
        step();
        reset = 1'b0;
        bus1.req0_valid = 1'b0;
        chk("rw_busy", bus3.busy, 32'd0);
        chk("rw_mul_en", bus3.mul_en, 32'd0);
        chk("rw_src", {bus3.mul_src1[15:0], bus3.mul_src2[15:0]}, 32'd0);
        chk("rw_result", bus3.rsp_result, 32'd0);
        chk("rw_dut1_idle", bus1.busy, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            seen = seen | bus3.rsp0_valid | bus3.rsp1_valid;
            step();
        end
        chk("rw_no_rsp", seen, 32'd0);
        bus3.req0_a = 32'h00020003; bus3.req0_b = 32'h00040005; bus3.req0_valid = 1'b1;
        bus3.req1_a = 32'h1;        bus3.req1_b = 32'h1;        bus3.req1_valid = 1'b1;
        #1;
        chk("rw_tie_p0", {bus3.req0_ready, bus3.req1_ready}, 32'd2);
        step();
        bus3.req0_valid = 1'b0;
        bus3.req1_valid = 1'b0;
        n = 0;
        while (!bus3.rsp0_valid && n < 20) begin step(); n++; end
        chk("rw_after_result", bus3.rsp_result, 32'h0016000F);
        step();

        // reset while dut1 is stalled in RESP
        bus1.rsp0_ready = 1'b0;
        bus1.req0_a = 32'h7; bus1.req0_b = 32'hFFFFFFFF; bus1.req0_valid = 1'b1;
        step();
        bus1.req0_valid = 1'b0;
        n = 0;
        while (!bus1.rsp0_valid && n < 20) begin step(); n++; end
        chk("rr_result", bus1.rsp_result, 32'hFFFFFFF9);
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus1.rsp0_ready = 1'b1;
        chk("rr_rsp0_valid", bus1.rsp0_valid, 32'd0);
        chk("rr_busy", bus1.busy, 32'd0);
        chk("rr_result_clr", bus1.rsp_result, 32'd0);
        chk("rr_src1", bus1.mul_src1, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            seen = seen | bus1.rsp0_valid | bus1.rsp1_valid;
            step();
        end
        chk("rr_no_rsp", seen, 32'd0);
        bus1.req0_a = 32'h12345678; bus1.req0_b = 32'h9ABCDEF0; bus1.req0_valid = 1'b1;
        bus1.req1_a = 32'h3;        bus1.req1_b = 32'h5;        bus1.req1_valid = 1'b1;
        #1;
        chk("rr_tie_p0", {bus1.req0_ready, bus1.req1_ready}, 32'd2);
        step();
        bus1.req0_valid = 1'b0;
        bus1.req1_valid = 1'b0;
        n = 0;
        while (!bus1.rsp0_valid && n < 20) begin step(); n++; end
        chk("rr_after_result", bus1.rsp_result, 32'h242D2080);
        step();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
